// File: rtl/l1_dir_agent.sv
// L1 cache controller for the directory protocol: 4 direct-mapped 16-bit lines in MSI,
// issues miss/write-back requests and answers directory invalidate/fetch messages.
module l1_dir_agent #(
  parameter int unsigned PROC_ID = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [1:0]  req_type,
  output logic [2:0]  req_addr,
  output logic [15:0] req_data,
  output logic        req_src,
  input  logic        dir_valid,
  output logic        dir_ready,
  input  logic [1:0]  dir_type,
  input  logic [2:0]  dir_addr,
  input  logic [15:0] dir_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_type,
  output logic [2:0]  rsp_addr,
  output logic [15:0] rsp_data
);
  localparam int unsigned LINES = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;

  localparam logic [1:0] LS_I = 2'b00;
  localparam logic [1:0] LS_S = 2'b01;
  localparam logic [1:0] LS_M = 2'b10;

  localparam logic [1:0] RQ_RD = 2'b00;
  localparam logic [1:0] RQ_WR = 2'b01;
  localparam logic [1:0] RQ_WB = 2'b10;

  localparam logic [1:0] DT_DATA  = 2'b00;
  localparam logic [1:0] DT_INV   = 2'b01;
  localparam logic [1:0] DT_FETCH = 2'b10;
  localparam logic [1:0] DT_FINV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WB_REQ, ST_MISS_REQ, ST_WAIT_REPLY, ST_RESPOND
  } fsm_e;

  fsm_e                      state_q, state_d, ret_q, ret_d;
  logic [LINES-1:0][1:0]     lst_q, lst_d;
  logic [LINES-1:0]          tag_q, tag_d;
  logic [LINES-1:0][DW-1:0]  data_q, data_d;
  logic                      pend_we_q, pend_we_d;
  logic [AW-1:0]             pend_addr_q, pend_addr_d;
  logic [DW-1:0]             pend_wdata_q, pend_wdata_d;
  logic                      cpu_done_q, cpu_done_d;
  logic [DW-1:0]             cpu_rdata_q, cpu_rdata_d;
  logic                      req_valid_q, req_valid_d;
  logic [1:0]                req_type_q, req_type_d;
  logic [AW-1:0]             req_addr_q, req_addr_d;
  logic [DW-1:0]             req_data_q, req_data_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_type_q, rsp_type_d;
  logic [AW-1:0]             rsp_addr_q, rsp_addr_d;
  logic [DW-1:0]             rsp_data_q, rsp_data_d;

  logic [1:0] cpu_idx, dir_idx, pend_idx;
  logic       cpu_hit, dir_hit, dir_fire;
  logic [DW-1:0] fill_data;

  // Ready signals are gated by reset so nothing is offered while reset is held.
  assign cpu_ready = reset_n && (state_q == ST_IDLE) && !dir_valid;
  assign dir_ready = reset_n && ((state_q == ST_IDLE) || (state_q == ST_WAIT_REPLY));

  assign cpu_idx   = cpu_addr[1:0];
  assign dir_idx   = dir_addr[1:0];
  assign pend_idx  = pend_addr_q[1:0];
  assign cpu_hit   = (lst_q[cpu_idx] != LS_I) && (tag_q[cpu_idx] == cpu_addr[2]);
  assign dir_hit   = (lst_q[dir_idx] != LS_I) && (tag_q[dir_idx] == dir_addr[2]);
  assign dir_fire  = dir_valid && dir_ready;
  assign fill_data = pend_we_q ? pend_wdata_q : dir_data;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    lst_d        = lst_q;
    tag_d        = tag_q;
    data_d       = data_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    cpu_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    req_valid_d  = req_valid_q;
    req_type_d   = req_type_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_type_d   = rsp_type_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_data_d   = rsp_data_q;

    if (dir_fire && (dir_type != DT_DATA)) begin
      // Coherence messages are serviced from IDLE or WAIT_REPLY; the response always goes out.
      rsp_valid_d = 1'b1;
      rsp_type_d  = (dir_type != DT_INV);
      rsp_addr_d  = dir_addr;
      rsp_data_d  = (dir_type == DT_INV) ? DW'(0) : data_q[dir_idx];
      ret_d       = state_q;
      state_d     = ST_RESPOND;
      if (dir_hit) begin
        case (dir_type)
          DT_INV, DT_FINV: lst_d[dir_idx] = LS_I;
          DT_FETCH:        if (lst_q[dir_idx] == LS_M) lst_d[dir_idx] = LS_S;
          default:         ;
        endcase
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_valid && cpu_ready) begin
            pend_we_d    = cpu_we;
            pend_addr_d  = cpu_addr;
            pend_wdata_d = cpu_wdata;
            if (cpu_hit && !cpu_we) begin
              cpu_done_d  = 1'b1;
              cpu_rdata_d = data_q[cpu_idx];
            end else if (cpu_hit && (lst_q[cpu_idx] == LS_M)) begin
              data_d[cpu_idx] = cpu_wdata;
              cpu_done_d      = 1'b1;
              cpu_rdata_d     = cpu_wdata;
            end else if (cpu_hit || (lst_q[cpu_idx] != LS_M)) begin
              state_d     = ST_MISS_REQ;
              req_valid_d = 1'b1;
              req_type_d  = cpu_we ? RQ_WR : RQ_RD;
              req_addr_d  = cpu_addr;
              req_data_d  = DW'(0);
            end else begin
              state_d         = ST_WB_REQ;
              req_valid_d     = 1'b1;
              req_type_d      = RQ_WB;
              req_addr_d      = {tag_q[cpu_idx], cpu_idx};
              req_data_d      = data_q[cpu_idx];
              lst_d[cpu_idx]  = LS_I;
            end
          end
        end
        ST_WB_REQ: begin
          if (req_ready) begin
            state_d    = ST_MISS_REQ;
            req_type_d = pend_we_q ? RQ_WR : RQ_RD;
            req_addr_d = pend_addr_q;
            req_data_d = DW'(0);
          end
        end
        ST_MISS_REQ: begin
          if (req_ready) begin
            req_valid_d = 1'b0;
            state_d     = ST_WAIT_REPLY;
          end
        end
        ST_WAIT_REPLY: begin
          // Data replies for any other address are consumed and dropped.
          if (dir_fire && (dir_addr == pend_addr_q)) begin
            lst_d[pend_idx]  = pend_we_q ? LS_M : LS_S;
            tag_d[pend_idx]  = pend_addr_q[2];
            data_d[pend_idx] = fill_data;
            cpu_done_d       = 1'b1;
            cpu_rdata_d      = fill_data;
            state_d          = ST_IDLE;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = ret_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      lst_q        <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      cpu_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      req_valid_q  <= 1'b0;
      req_type_q   <= '0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_type_q   <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      lst_q        <= lst_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      cpu_done_q   <= cpu_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      req_valid_q  <= req_valid_d;
      req_type_q   <= req_type_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_type_q   <= rsp_type_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign req_valid = req_valid_q;
  assign req_type  = req_type_q;
  assign req_addr  = req_addr_q;
  assign req_data  = req_data_q;
  assign req_src   = 1'(PROC_ID);
  assign rsp_valid = rsp_valid_q;
  assign rsp_type  = rsp_type_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_l1_dir_agent.sv
// Directed bench for l1_dir_agent: the bench plays processor and directory.
module tb_l1_dir_agent;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_valid = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ready, cpu_done;
  logic [15:0] cpu_rdata;
  logic        req_valid, req_src;
  logic        req_ready = 1'b0;
  logic [1:0]  req_type;
  logic [2:0]  req_addr;
  logic [15:0] req_data;
  logic        dir_valid = 1'b0;
  logic        dir_ready;
  logic [1:0]  dir_type = '0;
  logic [2:0]  dir_addr = '0;
  logic [15:0] dir_data = '0;
  logic        rsp_valid, rsp_type;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_addr;
  logic [15:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  l1_dir_agent #(.PROC_ID(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_addr(req_addr),
    .req_data(req_data), .req_src(req_src),
    .dir_valid(dir_valid), .dir_ready(dir_ready), .dir_type(dir_type), .dir_addr(dir_addr),
    .dir_data(dir_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data)
  );

  always #5 clock = ~clock;

  // Drivers: each is entered at or after a falling edge and returns on the falling edge after the handshake.
  task automatic cpu_req(input logic we, input logic [2:0] a, input logic [15:0] d);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clock); @(negedge clock);
    cpu_valid = 1'b0;
  endtask

  task automatic req_accept();
    req_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    req_ready = 1'b0;
  endtask

  task automatic dir_send(input logic [1:0] t, input logic [2:0] a, input logic [15:0] d);
    dir_valid = 1'b1; dir_type = t; dir_addr = a; dir_data = d;
    @(posedge clock); @(negedge clock);
    dir_valid = 1'b0;
  endtask

  task automatic rsp_accept();
    rsp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic miss_fill(input logic we, input logic [2:0] a, input logic [15:0] wd, input logic [15:0] rd);
    cpu_req(we, a, wd);
    req_accept();
    dir_send(2'b00, a, rd);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (dir_ready !== 1'b0) begin n_bad++; $display("FAIL rst_dir_ready: got %b want 0", dir_ready); end
    n_cmp++; if ({req_valid, rsp_valid, cpu_done} !== 3'b000) begin n_bad++; $display("FAIL rst_valids: got %b want 000", {req_valid, rsp_valid, cpu_done}); end
    n_cmp++; if ({req_addr, req_data, req_type, rsp_addr, rsp_data, cpu_rdata} !== 56'h0) begin n_bad++; $display("FAIL rst_payload: got %h want 0", {req_addr, req_data, req_type, rsp_addr, rsp_data, cpu_rdata}); end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rel_cpu_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (dir_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rel_dir_ready: got %b want 1", dir_ready); end
    @(negedge clock);
  endtask

  task automatic test_read_miss();
    cpu_req(1'b0, 3'd0, 16'h0);
    n_cmp++; if ({req_valid, req_type, req_addr} !== {1'b1, 2'b00, 3'd0}) begin n_bad++; $display("FAIL rdmiss_req: got v%b t%b a%0d want v1 t00 a0", req_valid, req_type, req_addr); end
    n_cmp++; if ({req_data, req_src} !== 17'h0) begin n_bad++; $display("FAIL rdmiss_req_data_src: got %h/%b want 0/0", req_data, req_src); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rdmiss_busy: cpu_ready got %b want 0", cpu_ready); end
    req_accept();
    n_cmp++; if ({req_valid, dir_ready} !== 2'b01) begin n_bad++; $display("FAIL rdmiss_wait: got req_valid/dir_ready %b want 01", {req_valid, dir_ready}); end
    dir_send(2'b00, 3'd0, 16'h000A);
    n_cmp++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'h000A}) begin n_bad++; $display("FAIL rdmiss_done: got %b/%h want 1/000a", cpu_done, cpu_rdata); end
    @(negedge clock);
    n_cmp++; if (cpu_done !== 1'b0) begin n_bad++; $display("FAIL rdmiss_done_pulse: got %b want 0", cpu_done); end
    cpu_req(1'b0, 3'd0, 16'h0);
    n_cmp++; if ({cpu_done, cpu_rdata, req_valid} !== {1'b1, 16'h000A, 1'b0}) begin n_bad++; $display("FAIL rdhit: got done%b rd%h req%b want 1/000a/0", cpu_done, cpu_rdata, req_valid); end
    @(negedge clock);
  endtask

  task automatic test_write_upgrade();
    miss_fill(1'b0, 3'd1, 16'h0, 16'h0011);
    cpu_req(1'b1, 3'd1, 16'h1234);
    n_cmp++; if ({req_valid, req_type, req_addr} !== {1'b1, 2'b01, 3'd1}) begin n_bad++; $display("FAIL upg_req: got v%b t%b a%0d want v1 t01 a1", req_valid, req_type, req_addr); end
    req_accept();
    dir_send(2'b00, 3'd1, 16'h0BAD);
    n_cmp++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'h1234}) begin n_bad++; $display("FAIL upg_done: got %b/%h want 1/1234", cpu_done, cpu_rdata); end
    @(negedge clock);
    cpu_req(1'b0, 3'd1, 16'h0);
    n_cmp++; if ({cpu_done, cpu_rdata, req_valid} !== {1'b1, 16'h1234, 1'b0}) begin n_bad++; $display("FAIL upg_rdhit: got done%b rd%h req%b want 1/1234/0", cpu_done, cpu_rdata, req_valid); end
    @(negedge clock);
  endtask

  task automatic test_writeback();
    miss_fill(1'b1, 3'd2, 16'h0044, 16'h0);
    cpu_req(1'b0, 3'd6, 16'h0);
    n_cmp++; if ({req_valid, req_type, req_addr, req_data} !== {1'b1, 2'b10, 3'd2, 16'h0044}) begin n_bad++; $display("FAIL wb_req: got v%b t%b a%0d d%h want v1 t10 a2 d0044", req_valid, req_type, req_addr, req_data); end
    req_accept();
    n_cmp++; if ({req_valid, req_type, req_addr, req_data} !== {1'b1, 2'b00, 3'd6, 16'h0}) begin n_bad++; $display("FAIL wb_miss_req: got v%b t%b a%0d d%h want v1 t00 a6 d0000", req_valid, req_type, req_addr, req_data); end
    req_accept();
    dir_send(2'b00, 3'd6, 16'h0066);
    n_cmp++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'h0066}) begin n_bad++; $display("FAIL wb_done: got %b/%h want 1/0066", cpu_done, cpu_rdata); end
    @(negedge clock);
  endtask

  task automatic test_fetch();
    miss_fill(1'b1, 3'd3, 16'h0012, 16'h0);
    dir_send(2'b10, 3'd3, 16'h0);
    n_cmp++; if ({rsp_valid, rsp_type, rsp_addr, rsp_data} !== {1'b1, 1'b1, 3'd3, 16'h0012}) begin n_bad++; $display("FAIL fetch_rsp: got v%b t%b a%0d d%h want v1 t1 a3 d0012", rsp_valid, rsp_type, rsp_addr, rsp_data); end
    n_cmp++; if ({cpu_ready, dir_ready} !== 2'b00) begin n_bad++; $display("FAIL fetch_busy: got %b want 00", {cpu_ready, dir_ready}); end
    @(negedge clock);
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, 16'h0012}) begin n_bad++; $display("FAIL fetch_hold: got %b/%h want 1/0012", rsp_valid, rsp_data); end
    rsp_accept();
    n_cmp++; if ({rsp_valid, cpu_ready} !== 2'b01) begin n_bad++; $display("FAIL fetch_ret: got %b want 01", {rsp_valid, cpu_ready}); end
    cpu_req(1'b1, 3'd3, 16'h0033);
    n_cmp++; if ({req_valid, req_type, req_addr} !== {1'b1, 2'b01, 3'd3}) begin n_bad++; $display("FAIL fetch_now_s: got v%b t%b a%0d want v1 t01 a3", req_valid, req_type, req_addr); end
    req_accept();
    dir_send(2'b00, 3'd3, 16'h0);
    @(negedge clock);
    dir_send(2'b01, 3'd3, 16'h0);
    n_cmp++; if ({rsp_valid, rsp_type, rsp_addr, rsp_data} !== {1'b1, 1'b0, 3'd3, 16'h0}) begin n_bad++; $display("FAIL inv_ack: got v%b t%b a%0d d%h want v1 t0 a3 d0000", rsp_valid, rsp_type, rsp_addr, rsp_data); end
    rsp_accept();
    cpu_req(1'b0, 3'd3, 16'h0);
    n_cmp++; if ({req_valid, req_type, req_addr} !== {1'b1, 2'b00, 3'd3}) begin n_bad++; $display("FAIL inv_now_i: got v%b t%b a%0d want v1 t00 a3", req_valid, req_type, req_addr); end
    req_accept();
    dir_send(2'b00, 3'd3, 16'h0003);
    @(negedge clock);
    dir_send(2'b11, 3'd7, 16'h0);
    n_cmp++; if ({rsp_valid, rsp_type, rsp_addr, rsp_data} !== {1'b1, 1'b1, 3'd7, 16'h0003}) begin n_bad++; $display("FAIL finv_mismatch_rsp: got v%b t%b a%0d d%h want v1 t1 a7 d0003", rsp_valid, rsp_type, rsp_addr, rsp_data); end
    rsp_accept();
    cpu_req(1'b0, 3'd3, 16'h0);
    n_cmp++; if ({cpu_done, cpu_rdata, req_valid} !== {1'b1, 16'h0003, 1'b0}) begin n_bad++; $display("FAIL finv_mismatch_keep: got done%b rd%h req%b want 1/0003/0", cpu_done, cpu_rdata, req_valid); end
    @(negedge clock);
  endtask

  task automatic test_inv_during_wait();
    dir_send(2'b01, 3'd0, 16'h0);
    rsp_accept();
    cpu_req(1'b0, 3'd0, 16'h0);
    n_cmp++; if ({req_valid, req_type, req_addr} !== {1'b1, 2'b00, 3'd0}) begin n_bad++; $display("FAIL iw_req: got v%b t%b a%0d want v1 t00 a0", req_valid, req_type, req_addr); end
    req_accept();
    dir_send(2'b01, 3'd1, 16'h0);
    n_cmp++; if ({rsp_valid, rsp_type, rsp_addr} !== {1'b1, 1'b0, 3'd1}) begin n_bad++; $display("FAIL iw_ack: got v%b t%b a%0d want v1 t0 a1", rsp_valid, rsp_type, rsp_addr); end
    rsp_accept();
    n_cmp++; if ({dir_ready, cpu_ready, cpu_done} !== 3'b100) begin n_bad++; $display("FAIL iw_back_wait: got %b want 100", {dir_ready, cpu_ready, cpu_done}); end
    dir_send(2'b00, 3'd5, 16'h5555);
    n_cmp++; if ({cpu_done, rsp_valid, dir_ready} !== 3'b001) begin n_bad++; $display("FAIL iw_drop: got %b want 001", {cpu_done, rsp_valid, dir_ready}); end
    dir_send(2'b00, 3'd0, 16'h00A0);
    n_cmp++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'h00A0}) begin n_bad++; $display("FAIL iw_done: got %b/%h want 1/00a0", cpu_done, cpu_rdata); end
    @(negedge clock);
  endtask

  task automatic test_stall_reset();
    cpu_req(1'b0, 3'd1, 16'h0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({req_valid, req_type, req_addr, req_data, cpu_ready} !== {1'b1, 2'b00, 3'd1, 16'h0, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v%b t%b a%0d d%h rdy%b want v1 t00 a1 d0000 rdy0", i, req_valid, req_type, req_addr, req_data, cpu_ready);
      end
      @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({req_valid, rsp_valid, cpu_done, cpu_ready, dir_ready} !== 5'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got %b want 00000", {req_valid, rsp_valid, cpu_done, cpu_ready, dir_ready}); end
    n_cmp++; if ({req_addr, req_data, req_type, rsp_addr, rsp_data, cpu_rdata} !== 56'h0) begin n_bad++; $display("FAIL mid_rst_payload: got %h want 0", {req_addr, req_data, req_type, rsp_addr, rsp_data, cpu_rdata}); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    cpu_req(1'b0, 3'd0, 16'h0);
    n_cmp++; if ({req_valid, req_type, req_addr, cpu_done} !== {1'b1, 2'b00, 3'd0, 1'b0}) begin n_bad++; $display("FAIL post_rst_miss: got v%b t%b a%0d done%b want v1 t00 a0 done0", req_valid, req_type, req_addr, cpu_done); end
    req_accept();
    dir_send(2'b00, 3'd0, 16'h0777);
    n_cmp++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'h0777}) begin n_bad++; $display("FAIL post_rst_done: got %b/%h want 1/0777", cpu_done, cpu_rdata); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_upgrade();
    test_writeback();
    test_fetch();
    test_inv_during_wait();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1);
  end
endmodule
